// File: rtl/scroll_engine_pkg.sv
// Shared types for the scroll engine: FSM states, request record and step normalisation.
package scroll_engine_pkg;

  localparam int unsigned ConsoleLines   = 50;
  localparam int unsigned ConsoleColumns = 80;
  localparam int unsigned ConsoleDataW   = 16;

  typedef enum logic [2:0] {
    StIdle,
    StCopy,
    StDrain,
    StBlank,
    StDone
  } scroll_state_e;

  // The blank cell is carried beside this record because its width is a module parameter.
  typedef struct packed {
    logic       dir;
    logic [7:0] step;
    logic [7:0] top;
    logic [7:0] bottom;
  } scroll_req_t;

  // step 0 means 1; a step larger than the region clamps to the region height.
  function automatic logic [7:0] norm_step(input scroll_req_t r);
    logic [7:0] s;
    logic [7:0] span;
    s    = (r.step == 8'd0) ? 8'd1 : r.step;
    span = r.bottom - r.top + 8'd1;
    return (s > span) ? span : s;
  endfunction

endpackage

// File: rtl/scroll_engine_if.sv
// Request and text-RAM bundle between the cursor stage, the scroll engine and the RAM.
interface scroll_engine_if #(
  parameter int unsigned DATA_W = 16
);
  logic              scroll_valid;
  logic              scroll_dir;
  logic [7:0]        scroll_step;
  logic [7:0]        scroll_top;
  logic [7:0]        scroll_bottom;
  logic [DATA_W-1:0] blank_data;
  logic              rd_en;
  logic [7:0]        rd_row;
  logic [7:0]        rd_col;
  logic [DATA_W-1:0] rd_data;
  logic              wr_en;
  logic [7:0]        wr_row;
  logic [7:0]        wr_col;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output scroll_valid, scroll_dir, scroll_step, scroll_top, scroll_bottom, blank_data, rd_data,
    input  rd_en, rd_row, rd_col, wr_en, wr_row, wr_col, wr_data
  );

  modport slave (
    input  scroll_valid, scroll_dir, scroll_step, scroll_top, scroll_bottom, blank_data, rd_data,
    output rd_en, rd_row, rd_col, wr_en, wr_row, wr_col, wr_data
  );
endinterface

// File: rtl/scroll_cell_walker.sv
// Row/column walker: columns ascend and wrap, rows step up or down from a start row to an end row.
module scroll_cell_walker #(
  parameter int unsigned COLUMNS = 80
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic       down_i,
  input  logic [7:0] start_i,
  input  logic [7:0] end_i,
  input  logic       adv_i,
  output logic [7:0] row_o,
  output logic [7:0] col_o,
  output logic       last_o
);
  localparam logic [7:0] ColMax = 8'(COLUMNS - 1);

  logic [7:0] row_q, row_d, col_q, col_d, end_q, end_d;
  logic       down_q, down_d;

  always_comb begin
    row_d  = row_q;
    col_d  = col_q;
    end_d  = end_q;
    down_d = down_q;
    if (load_i) begin
      row_d  = start_i;
      col_d  = 8'd0;
      end_d  = end_i;
      down_d = down_i;
    end else if (adv_i) begin
      if (col_q == ColMax) begin
        col_d = 8'd0;
        row_d = down_q ? row_q - 8'd1 : row_q + 8'd1;
      end else begin
        col_d = col_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q  <= '0;
      col_q  <= '0;
      end_q  <= '0;
      down_q <= 1'b0;
    end else begin
      row_q  <= row_d;
      col_q  <= col_d;
      end_q  <= end_d;
      down_q <= down_d;
    end
  end

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign last_o = (row_q == end_q) && (col_q == ColMax);
endmodule

// File: rtl/scroll_engine.sv
// Scroll engine: moves lines of the text RAM inside a region and blanks the vacated lines.
module scroll_engine
  import scroll_engine_pkg::*;
#(
  parameter int unsigned LINES   = ConsoleLines,
  parameter int unsigned COLUMNS = ConsoleColumns,
  parameter int unsigned DATA_W  = ConsoleDataW
) (
  input  logic            clk,
  input  logic            rst_n,
  scroll_engine_if.slave  bus_io,
  output logic            busy_o,
  output logic            done_o,
  output logic            overflow_o
);
  localparam logic [7:0] LinesB = 8'(LINES);

  scroll_state_e     state_q, state_d;
  scroll_req_t       req_q, req_d, pend_q, pend_d, in_req, start_req, nreq, rng;
  logic [DATA_W-1:0] blank_q, blank_d, pend_blank_q, pend_blank_d;
  logic              pend_valid_q, pend_valid_d, overflow_q, overflow_d;
  logic              cp_wr_q, cp_wr_d;
  logic [7:0]        cp_row_q, cp_row_d, cp_col_q, cp_col_d;
  logic              start_now, start_bad, rd_go, blank_wr;
  logic [7:0]        span, copy_start, copy_end, blank_start, blank_end, src_row;
  logic              w_load, w_down, w_adv, w_last;
  logic [7:0]        w_start, w_end, w_row, w_col;

  assign in_req = '{dir: bus_io.scroll_dir, step: bus_io.scroll_step,
                    top: bus_io.scroll_top, bottom: bus_io.scroll_bottom};

  // A pending request always wins over a new strobe; the strobe then refills the slot.
  assign start_now = (state_q == StIdle && (pend_valid_q || bus_io.scroll_valid)) ||
                     (state_q == StDone && pend_valid_q);
  assign start_req = pend_valid_q ? pend_q : in_req;
  assign start_bad = (start_req.top > start_req.bottom) || (start_req.bottom >= LinesB);

  always_comb begin
    nreq      = start_req;
    nreq.step = norm_step(start_req);
  end

  assign rng         = start_now ? nreq : req_q;
  assign span        = rng.bottom - rng.top + 8'd1;
  assign copy_start  = rng.dir ? rng.bottom : rng.top;
  assign copy_end    = rng.dir ? rng.top + rng.step : rng.bottom - rng.step;
  assign blank_start = rng.dir ? rng.top : rng.bottom - rng.step + 8'd1;
  assign blank_end   = rng.dir ? rng.top + rng.step - 8'd1 : rng.bottom;

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    blank_d      = blank_q;
    pend_d       = pend_q;
    pend_blank_d = pend_blank_q;
    pend_valid_d = pend_valid_q;
    overflow_d   = overflow_q;
    cp_wr_d      = 1'b0;
    cp_row_d     = cp_row_q;
    cp_col_d     = cp_col_q;
    w_load       = 1'b0;
    w_down       = 1'b0;
    w_start      = blank_start;
    w_end        = blank_end;
    w_adv        = 1'b0;
    rd_go        = 1'b0;
    blank_wr     = 1'b0;
    done_o       = 1'b0;

    unique case (state_q)
      StCopy: begin
        rd_go    = 1'b1;
        w_adv    = 1'b1;
        cp_wr_d  = 1'b1;
        cp_row_d = w_row;
        cp_col_d = w_col;
        if (w_last) begin
          state_d = StDrain;
          w_load  = 1'b1;
        end
      end
      StDrain: state_d = StBlank;
      StBlank: begin
        blank_wr = 1'b1;
        w_adv    = 1'b1;
        if (w_last) state_d = StDone;
      end
      StDone: begin
        done_o  = 1'b1;
        state_d = StIdle;
      end
      default: ;
    endcase

    if (start_now) begin
      req_d   = nreq;
      blank_d = pend_valid_q ? pend_blank_q : bus_io.blank_data;
      if (pend_valid_q) pend_valid_d = 1'b0;
      if (start_bad) begin
        state_d = StDone;
      end else if (nreq.step == span) begin
        state_d = StDrain;
        w_load  = 1'b1;
      end else begin
        state_d = StCopy;
        w_load  = 1'b1;
        w_down  = nreq.dir;
        w_start = copy_start;
        w_end   = copy_end;
      end
    end

    if (bus_io.scroll_valid && !(start_now && !pend_valid_q)) begin
      if (!pend_valid_q || start_now) begin
        pend_d       = in_req;
        pend_blank_d = bus_io.blank_data;
        pend_valid_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      req_q        <= '0;
      blank_q      <= '0;
      pend_q       <= '0;
      pend_blank_q <= '0;
      pend_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      cp_wr_q      <= 1'b0;
      cp_row_q     <= '0;
      cp_col_q     <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      blank_q      <= blank_d;
      pend_q       <= pend_d;
      pend_blank_q <= pend_blank_d;
      pend_valid_q <= pend_valid_d;
      overflow_q   <= overflow_d;
      cp_wr_q      <= cp_wr_d;
      cp_row_q     <= cp_row_d;
      cp_col_q     <= cp_col_d;
    end
  end

  scroll_cell_walker #(
    .COLUMNS(COLUMNS)
  ) u_walker (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (w_load),
    .down_i (w_down),
    .start_i(w_start),
    .end_i  (w_end),
    .adv_i  (w_adv),
    .row_o  (w_row),
    .col_o  (w_col),
    .last_o (w_last)
  );

  // Walker tracks the destination row; the source sits step rows away on the far side.
  assign src_row        = req_q.dir ? w_row - req_q.step : w_row + req_q.step;
  assign bus_io.rd_en   = rd_go;
  assign bus_io.rd_row  = rd_go ? src_row : 8'd0;
  assign bus_io.rd_col  = rd_go ? w_col : 8'd0;
  assign bus_io.wr_en   = cp_wr_q | blank_wr;
  assign bus_io.wr_row  = cp_wr_q ? cp_row_q : (blank_wr ? w_row : 8'd0);
  assign bus_io.wr_col  = cp_wr_q ? cp_col_q : (blank_wr ? w_col : 8'd0);
  assign bus_io.wr_data = cp_wr_q ? bus_io.rd_data : (blank_wr ? blank_q : '0);
  assign busy_o         = (state_q != StIdle) || pend_valid_q;
  assign overflow_o     = overflow_q;
endmodule

// File: tb/tb_scroll_engine.sv
// Bench for scroll_engine on an 8x4 RAM model preloaded with row*16+col.
module tb_scroll_engine;
  localparam int L = 8;
  localparam int C = 4;

  typedef struct {
    string       name;
    logic        dir;
    logic [7:0]  step;
    logic [7:0]  top;
    logic [7:0]  bottom;
    logic [15:0] blank;
    int          lat;
    int          wr;
    int          rd;
  } vec_t;

  typedef struct {
    string name;
    int    lat;
    int    wr;
    int    rd;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, done, overflow;
  logic load_img = 1'b0;
  logic [15:0] mem     [L][C];
  logic [15:0] exp_img [L][C];
  int wr_cnt = 0;
  int rd_cnt = 0;
  int coll_cnt = 0;
  int tests = 0;
  int fails = 0;
  exp_t sb[$];
  vec_t tab[8];

  scroll_engine_if #(.DATA_W(16)) bus ();

  scroll_engine #(
    .LINES (L),
    .COLUMNS(C),
    .DATA_W(16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus_io    (bus),
    .busy_o    (busy),
    .done_o    (done),
    .overflow_o(overflow)
  );

  always #5 clk = ~clk;

  // RAM model: read data one cycle after rd_en, reads see pre-write contents.
  always @(posedge clk) begin
    if (load_img) begin
      for (int r = 0; r < L; r++)
        for (int c = 0; c < C; c++) mem[r][c] <= 16'(r * 16 + c);
    end else if (bus.wr_en && bus.wr_row < 8'(L) && bus.wr_col < 8'(C)) begin
      mem[bus.wr_row[2:0]][bus.wr_col[1:0]] <= bus.wr_data;
    end
    if (bus.rd_en && bus.rd_row < 8'(L) && bus.rd_col < 8'(C))
      bus.rd_data <= mem[bus.rd_row[2:0]][bus.rd_col[1:0]];
    else
      bus.rd_data <= 16'h0;
    if (bus.wr_en) wr_cnt <= wr_cnt + 1;
    if (bus.rd_en) rd_cnt <= rd_cnt + 1;
    if (bus.rd_en && bus.wr_en && bus.rd_row == bus.wr_row && bus.rd_col == bus.wr_col)
      coll_cnt <= coll_cnt + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic apply_model(input logic dir, input int step, input int top, input int bottom,
                             input logic [15:0] blank);
    logic [15:0] old [L][C];
    int s, span;
    old = exp_img;
    if (top > bottom || bottom >= L) return;
    s    = (step == 0) ? 1 : step;
    span = bottom - top + 1;
    if (s > span) s = span;
    for (int r = top; r <= bottom; r++)
      for (int c = 0; c < C; c++)
        if (!dir) exp_img[r][c] = (r + s <= bottom) ? old[r + s][c] : blank;
        else      exp_img[r][c] = (r - s >= top) ? old[r - s][c] : blank;
  endtask

  task automatic preload();
    @(negedge clk);
    load_img = 1'b1;
    @(negedge clk);
    load_img = 1'b0;
    for (int r = 0; r < L; r++)
      for (int c = 0; c < C; c++) exp_img[r][c] = 16'(r * 16 + c);
  endtask

  task automatic strobe(input vec_t v);
    bus.scroll_valid  = 1'b1;
    bus.scroll_dir    = v.dir;
    bus.scroll_step   = v.step;
    bus.scroll_top    = v.top;
    bus.scroll_bottom = v.bottom;
    bus.blank_data    = v.blank;
  endtask

  task automatic drive(input vec_t v);
    exp_t e;
    strobe(v);
    e = '{name: v.name, lat: v.lat, wr: v.wr, rd: v.rd};
    sb.push_back(e);
    apply_model(v.dir, int'(v.step), int'(v.top), int'(v.bottom), v.blank);
  endtask

  task automatic check_image(input string name);
    for (int r = 0; r < L; r++)
      check($sformatf("%s row%0d", name, r),
            {mem[r][0], mem[r][1], mem[r][2], mem[r][3]},
            {exp_img[r][0], exp_img[r][1], exp_img[r][2], exp_img[r][3]});
  endtask

  task automatic run_vec(input vec_t v);
    int w0, r0, lat;
    exp_t e;
    preload();
    w0 = wr_cnt;
    r0 = rd_cnt;
    drive(v);
    lat = 0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      bus.scroll_valid = 1'b0;
      if (done) begin
        lat = k;
        break;
      end
    end
    e = sb.pop_front();
    check({e.name, " latency"}, 64'(lat), 64'(e.lat));
    @(negedge clk);
    check({e.name, " writes"}, 64'(wr_cnt - w0), 64'(e.wr));
    check({e.name, " reads"}, 64'(rd_cnt - r0), 64'(e.rd));
    check_image(e.name);
  endtask

  initial begin
    int w0, r0, d1, d2;
    exp_t e1, e2;
    vec_t v1, v2, v3;

    tab[0] = '{"up_full_s1",   1'b0, 8'd1, 8'd0, 8'd7, 16'hA0A0, 34, 32, 28};
    tab[1] = '{"down_2_5_s2",  1'b1, 8'd2, 8'd2, 8'd5, 16'hB1B1, 18, 16, 8};
    tab[2] = '{"up_s9_clamp",  1'b0, 8'd9, 8'd0, 8'd7, 16'hC2C2, 34, 32, 0};
    tab[3] = '{"down_s0",      1'b1, 8'd0, 8'd1, 8'd6, 16'hD3D3, 26, 24, 20};
    tab[4] = '{"bad_top_gt",   1'b0, 8'd1, 8'd5, 8'd3, 16'hE4E4, 1, 0, 0};
    tab[5] = '{"bad_bot_oob",  1'b1, 8'd1, 8'd2, 8'd8, 16'hF5F5, 1, 0, 0};
    tab[6] = '{"up_one_row",   1'b0, 8'd1, 8'd3, 8'd3, 16'h0606, 6, 4, 0};
    tab[7] = '{"down_full_s3", 1'b1, 8'd3, 8'd0, 8'd7, 16'h0707, 34, 32, 20};

    bus.scroll_valid  = 1'b0;
    bus.scroll_dir    = 1'b0;
    bus.scroll_step   = 8'd0;
    bus.scroll_top    = 8'd0;
    bus.scroll_bottom = 8'd0;
    bus.blank_data    = 16'h0;

    repeat (2) @(negedge clk);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset overflow", 64'(overflow), 64'd0);
    check("reset rd_en", 64'(bus.rd_en), 64'd0);
    check("reset wr_en", 64'(bus.wr_en), 64'd0);
    rst_n = 1'b1;

    foreach (tab[i]) run_vec(tab[i]);

    // Three back-to-back strobes: second queued, third dropped.
    v1 = tab[0];
    v2 = tab[1];
    v3 = tab[7];
    preload();
    w0 = wr_cnt;
    r0 = rd_cnt;
    drive(v1);
    @(negedge clk);
    drive(v2);
    @(negedge clk);
    strobe(v3);
    @(negedge clk);
    bus.scroll_valid = 1'b0;
    check("b2b overflow", 64'(overflow), 64'd1);
    d1 = 0;
    d2 = 0;
    for (int k = 3; k <= 300; k++) begin
      if (done) begin
        if (d1 == 0) begin
          d1 = k;
          check("b2b busy at first done", 64'(busy), 64'd1);
        end else begin
          d2 = k;
          break;
        end
      end
      @(negedge clk);
    end
    e1 = sb.pop_front();
    e2 = sb.pop_front();
    check("b2b first latency", 64'(d1), 64'(e1.lat));
    check("b2b second latency", 64'(d2 - d1), 64'(e2.lat));
    @(negedge clk);
    check("b2b idle after", 64'(busy), 64'd0);
    check("b2b writes", 64'(wr_cnt - w0), 64'(e1.wr + e2.wr));
    check("b2b reads", 64'(rd_cnt - r0), 64'(e1.rd + e2.rd));
    check_image("b2b");
    repeat (3) @(negedge clk);
    check("overflow sticky", 64'(overflow), 64'd1);

    // Reset in the middle of a copy pass.
    preload();
    strobe(tab[0]);
    @(negedge clk);
    bus.scroll_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("midcopy rd_en before reset", 64'(bus.rd_en), 64'd1);
    rst_n = 1'b0;
    #1;
    check("reset rd_en", 64'(bus.rd_en), 64'd0);
    check("reset wr_en", 64'(bus.wr_en), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset overflow", 64'(overflow), 64'd0);
    w0 = wr_cnt;
    repeat (2) @(negedge clk);
    check("writes during reset", 64'(wr_cnt - w0), 64'd0);
    rst_n = 1'b1;
    run_vec(tab[1]);
    run_vec(tab[3]);

    check("rd/wr same cell", 64'(coll_cnt), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end
endmodule
